ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 175 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative HI/LO multiply/divide unit (radix-2 shift-add and restoring divide)
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stallreq_o,
    output logic             done_o,
    output logic             dz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             is_mul, is_div, is_signed, a_neg, b_neg, last;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign is_mul    = (op_i[2:1] == 2'b00);
    assign is_div    = (op_i[2:1] == 2'b01);
    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & a_i[WIDTH-1];
    assign b_neg     = is_signed & b_i[WIDTH-1];
    assign a_abs     = a_neg ? -a_i : a_i;
    assign b_abs     = b_neg ? -b_i : b_i;
    assign last      = (cnt_q == CNT_W'(1));

    // Multiply step: acc holds the running upper half, low_q shifts the multiplier out.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod, mul_fix;

    assign mul_sum  = {1'b0, acc_q[WIDTH-1:0]} + (low_q[0] ? {1'b0, opb_q} : '0);
    assign mul_prod = {mul_sum, low_q[WIDTH-1:1]};
    assign mul_fix  = neg_q ? -mul_prod : mul_prod;

    // Restoring divide step: partial remainder in acc, dividend shifts out of low_q as quotient shifts in.
    logic [WIDTH:0]   div_shift, div_diff, div_rem;
    logic             div_ok;
    logic [WIDTH-1:0] div_quo, quo_fix, rem_fix;

    assign div_shift = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_rem   = div_ok ? div_diff : div_shift;
    assign div_quo   = {low_q[WIDTH-2:0], div_ok};
    assign quo_fix   = neg_q ? -div_quo : div_quo;
    assign rem_fix   = rneg_q ? -div_rem[WIDTH-1:0] : div_rem[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        low_d   = low_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (is_mul) begin
                            low_d   = a_abs;
                            opb_d   = b_abs;
                            acc_d   = '0;
                            neg_d   = a_neg ^ b_neg;
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = MUL;
                        end else if (is_div) begin
                            if (b_i == '0) begin
                                done_d  = 1'b1;
                                dz_d    = 1'b1;
                                state_d = DONE;
                            end else begin
                                low_d   = a_abs;
                                opb_d   = b_abs;
                                acc_d   = '0;
                                neg_d   = a_neg ^ b_neg;
                                rneg_d  = a_neg;
                                cnt_d   = CNT_W'(WIDTH);
                                state_d = DIV;
                            end
                        end else if (op_i == 3'b100) begin
                            hi_d = a_i;
                        end else if (op_i == 3'b101) begin
                            lo_d = a_i;
                        end
                    end
                end
                MUL: begin
                    acc_d = {1'b0, mul_sum[WIDTH:1]};
                    low_d = {mul_sum[0], low_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (last) begin
                        hi_d    = mul_fix[2*WIDTH-1:WIDTH];
                        lo_d    = mul_fix[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DIV: begin
                    acc_d = div_rem;
                    low_d = div_quo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (last) begin
                        hi_d    = rem_fix;
                        lo_d    = quo_fix;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            low_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            low_q   <= low_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign stallreq_o = (state_q == MUL) || (state_q == DIV) ||
                        ((state_q == IDLE) && start_i && (is_mul || is_div));
    assign done_o = done_q;
    assign dz_o   = dz_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv at WIDTH=32 and WIDTH=8
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [2:0]  op = 3'b110;
    logic [31:0] a = '0, b = '0;
    logic        flush = 1'b0;
    logic        stall32, done32, dz32, stall8, done8, dz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .op_i(op), .a_i(a), .b_i(b),
        .flush_i(flush), .stallreq_o(stall32), .done_o(done32), .dz_o(dz32),
        .hi_o(hi32), .lo_o(lo32)
    );

    ex_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op), .a_i(a[7:0]), .b_i(b[7:0]),
        .flush_i(flush), .stallreq_o(stall8), .done_o(done8), .dz_o(dz8),
        .hi_o(hi8), .lo_o(lo8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t;
    } exp_t;

    exp_t        q32[$], q8[$];
    exp_t        e32, e8;
    logic [31:0] sh_hi[2], sh_lo[2];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: 64-bit integer arithmetic, results masked to the unit width.
    function automatic logic [64:0] model(input int w, input logic [2:0] op_m,
                                          input logic [31:0] am, input logic [31:0] bm,
                                          input logic [31:0] hi0, input logic [31:0] lo0);
        logic [31:0] m, hi, lo;
        logic        dz;
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, pu;
        m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        ua = {32'b0, am & m};
        ub = {32'b0, bm & m};
        sa = (w == 32) ? longint'($signed(am)) : longint'($signed(am[7:0]));
        sb = (w == 32) ? longint'($signed(bm)) : longint'($signed(bm[7:0]));
        hi = hi0;
        lo = lo0;
        dz = 1'b0;
        case (op_m)
            3'b000: begin pu = sa * sb; hi = 32'(pu >> w) & m; lo = pu[31:0] & m; end
            3'b001: begin pu = ua * ub; hi = 32'(pu >> w) & m; lo = pu[31:0] & m; end
            3'b010: begin
                if (ub == 0) dz = 1'b1;
                else begin
                    sq = sa / sb; sr = sa % sb;
                    pu = sq; lo = pu[31:0] & m;
                    pu = sr; hi = pu[31:0] & m;
                end
            end
            3'b011: begin
                if (ub == 0) dz = 1'b1;
                else begin
                    pu = ua / ub; lo = pu[31:0];
                    pu = ua % ub; hi = pu[31:0];
                end
            end
            3'b100: hi = am & m;
            3'b101: lo = am & m;
            default: ;
        endcase
        return {dz, hi, lo};
    endfunction

    always @(negedge clk) begin
        if (!rst && done32) begin
            if (q32.size() == 0) check_eq("done32_unexpected", 1, 0);
            else begin
                e32 = q32.pop_front();
                check_eq("hi32", hi32, e32.hi);
                check_eq("lo32", lo32, e32.lo);
                check_eq("dz32", dz32, e32.dz);
                check_eq("done32_cycle", cyc, e32.t);
            end
        end
        if (!rst && dz32 && !done32) check_eq("dz32_stray", dz32, 0);
        if (!rst && done8) begin
            if (q8.size() == 0) check_eq("done8_unexpected", 1, 0);
            else begin
                e8 = q8.pop_front();
                check_eq("hi8", hi8, e8.hi);
                check_eq("lo8", lo8, e8.lo);
                check_eq("dz8", dz8, e8.dz);
                check_eq("done8_cycle", cyc, e8.t);
            end
        end
        if (!rst && dz8 && !done8) check_eq("dz8_stray", dz8, 0);
    end

    task automatic issue(input int sel, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input bit track);
        logic [64:0] r;
        exp_t        e;
        int          w;
        w = (sel == 0) ? 32 : 8;
        @(negedge clk);
        op = o; a = av; b = bv;
        if (sel == 0) start32 = 1'b1; else start8 = 1'b1;
        #1;
        check_eq("stall_on_request", (sel == 0) ? stall32 : stall8, o[2] == 1'b0);
        @(posedge clk);
        #1;
        if (sel == 0) start32 = 1'b0; else start8 = 1'b0;
        if (track) begin
            r = model(w, o, av, bv, sh_hi[sel], sh_lo[sel]);
            if (o[2] == 1'b0) begin
                e.hi = r[63:32]; e.lo = r[31:0]; e.dz = r[64];
                e.t  = cyc + (r[64] ? 0 : w);
                if (sel == 0) q32.push_back(e); else q8.push_back(e);
            end else begin
                check_eq("hi_direct", (sel == 0) ? hi32 : {24'b0, hi8}, r[63:32]);
                check_eq("lo_direct", (sel == 0) ? lo32 : {24'b0, lo8}, r[31:0]);
            end
            sh_hi[sel] = r[63:32];
            sh_lo[sel] = r[31:0];
        end
    endtask

    task automatic drain(input int sel);
        int budget;
        budget = 100;
        while (((sel == 0) ? q32.size() : q8.size()) != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) check_eq("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] minv, rb;
    logic [2:0]  rop;

    initial begin
        sh_hi[0] = '0; sh_lo[0] = '0; sh_hi[1] = '0; sh_lo[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_hi", hi32, 0);
        check_eq("rst_lo", lo32, 0);
        check_eq("rst_done", done32, 0);
        check_eq("rst_dz", dz32, 0);
        check_eq("rst_stall", stall32, 0);

        // MULT -3*5 with stall trace
        issue(0, 3'b000, 32'hFFFF_FFFD, 32'd5, 1);
        for (int k = 0; k < 32; k++) begin
            check_eq("stall_busy", stall32, 1);
            @(posedge clk);
            #1;
        end
        check_eq("stall_done", stall32, 0);
        check_eq("done_at_t0_33", done32, 1);
        drain(0);
        check_eq("mult_hi", hi32, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo32, 32'hFFFF_FFF1);

        issue(0, 3'b011, 32'd100, 32'd7, 1); drain(0);
        check_eq("divu_lo", lo32, 32'h0000_000E);
        check_eq("divu_hi", hi32, 32'h0000_0002);
        issue(0, 3'b010, 32'hFFFF_FFF9, 32'd2, 1); drain(0);
        check_eq("div_lo", lo32, 32'hFFFF_FFFD);
        check_eq("div_hi", hi32, 32'hFFFF_FFFF);
        issue(0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1); drain(0);
        check_eq("divmin_lo", lo32, 32'h8000_0000);
        check_eq("divmin_hi", hi32, 32'h0000_0000);
        issue(0, 3'b011, 32'd55, 32'd0, 1);
        check_eq("dz_done", done32, 1);
        check_eq("dz_flag", dz32, 1);
        drain(0);
        check_eq("dz_keep_lo", lo32, 32'h8000_0000);
        check_eq("dz_keep_hi", hi32, 32'h0000_0000);

        // Flush a MULTU mid-flight
        issue(0, 3'b001, 32'h1234_5678, 32'h0000_0100, 0);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_idle", stall32, 0);
        check_eq("flush_no_done", done32, 0);
        check_eq("flush_hi", hi32, sh_hi[0]);
        check_eq("flush_lo", lo32, sh_lo[0]);
        repeat (40) @(posedge clk);
        issue(0, 3'b001, 32'h1234_5678, 32'h0000_0100, 1); drain(0);

        // MTHI/MTLO back-to-back, then no-op
        issue(0, 3'b100, 32'h1234_5678, 32'd0, 1);
        issue(0, 3'b101, 32'h9ABC_DEF0, 32'd0, 1);
        check_eq("mthi_val", hi32, 32'h1234_5678);
        check_eq("mtlo_val", lo32, 32'h9ABC_DEF0);
        issue(0, 3'b110, 32'hDEAD_BEEF, 32'd3, 1);
        repeat (3) @(posedge clk);

        // start_i during MUL must be ignored
        issue(0, 3'b000, 32'h0000_7FFF, 32'hFFFF_0003, 1);
        @(negedge clk);
        op = 3'b100; a = 32'hDEAD_BEEF; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        drain(0);

        // Reset mid-DIV
        issue(0, 3'b010, 32'h0F00_0000, 32'd3, 0);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rstmid_hi", hi32, 0);
        check_eq("rstmid_lo", lo32, 0);
        check_eq("rstmid_done", done32, 0);
        check_eq("rstmid_idle", stall32, 0);
        rst = 1'b0;
        sh_hi[0] = '0; sh_lo[0] = '0; sh_hi[1] = '0; sh_lo[1] = '0;
        repeat (40) @(posedge clk);

        // Directed table at WIDTH=8 plus random traffic on both widths
        minv = 32'h0000_0080;
        issue(1, 3'b000, 32'hFFFF_FFFD, 32'd5, 1); drain(1);
        issue(1, 3'b011, 32'd100, 32'd7, 1); drain(1);
        issue(1, 3'b010, 32'hFFFF_FFF9, 32'd2, 1); drain(1);
        issue(1, 3'b010, minv, 32'hFFFF_FFFF, 1); drain(1);
        issue(1, 3'b011, 32'd9, 32'd0, 1); drain(1);
        issue(1, 3'b100, 32'h0000_0012, 32'd0, 1);
        issue(1, 3'b101, 32'h0000_00F0, 32'd0, 1);
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            issue((i < 40) ? 1 : 0, rop, ($urandom_range(0, 5) == 0) ? 32'hFFFF_FF80 : $urandom,
                  rb, 1);
            drain((i < 40) ? 1 : 0);
        end
        repeat (5) @(posedge clk);
        check_eq("q32_empty", q32.size(), 0);
        check_eq("q8_empty", q8.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
